uart_tx: RTL and testbench

- Serial transmitter for the 8N1 link whose receive side is the oversampling UART receiver.
- Accepts one byte per valid/ready handshake and shifts it out on `tx`: start bit, 8 data bits LSB first, stop bit.
- Each bit lasts CLKS_PER_BIT clock cycles. The default of 16 matches the receiver's 16x oversampling period.
- Sits between the byte-producing logic and the board TX pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_bit_timer.sv | 35 +++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receiver),
// data width and default bit period.
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int IDX_W            = $clog2(DATA_W);
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-producer to transmitter handshake bundle.
// A byte moves when data_valid && ready are both high at a rising clk edge;
// data is only looked at on that edge and ready never depends on data_valid.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              ready;

  modport master (output data, output data_valid, input ready);
  modport slave  (input data, input data_valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps on bit_end, held at 0
// while clear_i is high.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with registered outputs and a valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    bus,
  output logic        tx,
  output logic        tx_done,
  output uart_state_e state_dbg
);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              tx_q,    tx_d;
  logic              ready_q, ready_d;
  logic              done_q,  done_d;
  logic              timer_clr;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clr),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    timer_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        ready_d   = 1'b1;
        timer_clr = 1'b1;
        if (bus.data_valid && ready_q) begin
          shift_d = bus.data;
          idx_d   = '0;
          state_d = S_START;
          ready_d = 1'b0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          // Parity comes from the byte as accepted, not the shifting copy.
          parity_d = even_parity(bus.data);
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q != IDX_W'(DATA_W - 1)) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[1];
          end else begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings fall back to a quiet, idle line.
        state_d   = S_IDLE;
        tx_d      = 1'b1;
        ready_d   = 1'b1;
        timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.ready = ready_q;
  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table-driven frames, directed corner sequences and
// random traffic against a frame-level model plus a loopback receiver.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        tx;
  logic        tx_done;
  uart_state_e state_dbg;

  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx        (tx),
    .tx_done   (tx_done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;  // {stop, d7..d0, start}
    logic       exp_par;
  } vec_t;

  vec_t tbl[8];

  // ---------------- model / scoreboard state ----------------
  int               vectors = 0;
  int               miscompares = 0;
  logic [7:0]       exp_q[$];
  bit               m_busy;
  int               m_t;
  logic [7:0]       m_byte;
  logic [NBITS-1:0] cap_bits;
  int               ready_low;
  bit               rx_busy;
  int               rx_cnt;
  logic [7:0]       rx_byte;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Line level at offset t cycles after the acceptance edge.
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // One clock: model update, per-cycle compare, frame capture, loopback rx.
  task automatic step();
    logic       dv_s;
    logic [7:0] d_s;
    logic       done_e;
    logic       tx_e;
    int         k;
    dv_s = bus.data_valid;
    d_s  = bus.data;
    @(posedge clk);
    done_e = 1'b0;
    if (m_busy) begin
      m_t++;
      if (m_t == FRAME) begin
        m_busy = 1'b0;
        done_e = 1'b1;
      end
    end else if (dv_s) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_byte = d_s;
      exp_q.push_back(d_s);
    end
    tx_e = m_busy ? frame_bit(m_byte, m_t) : 1'b1;
    #1;
    check("cycle {tx,ready,tx_done}", {tx, bus.ready, tx_done}, {tx_e, ~m_busy, done_e});
    if (m_busy && (m_t % CPB == CPB / 2)) cap_bits[m_t / CPB] = tx;
    if (!bus.ready) ready_low++;

    if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_busy && (rx_cnt % CPB == CPB / 2)) begin
      k = rx_cnt / CPB;
      if (k == 0) begin
        check("rx start bit", tx, 1'b0);
      end else if (k <= 8) begin
        rx_byte[k-1] = tx;
`ifdef UART_TX_PARITY_EN
      end else if (k == 9) begin
        if (exp_q.size() > 0) check("rx parity bit", tx, ^exp_q[0]);
`endif
      end else begin
        check("rx stop bit", tx, 1'b1);
        check("rx frame expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("rx byte", rx_byte, exp_q.pop_front());
        rx_busy = 1'b0;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b);
    int n;
    bit seen;
    cap_bits  = '0;
    ready_low = 0;
    bus.data       = b;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < FRAME + 8) begin
      step();
      n++;
      if (tx_done) seen = 1'b1;
    end
    check("tx_done latency", n, FRAME);
    check("ready low cycles", ready_low, FRAME);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("frame completes (ready)", bus.ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap;
    int run;
    int n;
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h3C, 10'b1001111000, 1'b0};
    tbl[4] = '{8'h01, 10'b1000000010, 1'b1};
    tbl[5] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[6] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[7] = '{8'h5A, 10'b1010110100, 1'b0};

    rst            = 1'b1;
    bus.data       = 8'h00;
    bus.data_valid = 1'b0;
    m_busy         = 1'b0;
    m_t            = 0;
    m_byte         = 8'h00;
    rx_busy        = 1'b0;
    rx_cnt         = 0;
    rx_byte        = 8'h00;
    #1;
    check("reset tx", tx, 1'b1);
    check("reset ready", bus.ready, 1'b1);
    check("reset tx_done", tx_done, 1'b0);
    check("reset state", state_dbg, S_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle line after reset
    repeat (50) step();

    // Table-driven single frames
    foreach (tbl[i]) begin
      run_frame(tbl[i].data);
      check("frame bits", {cap_bits[NBITS-1], cap_bits[8:0]}, tbl[i].exp_frame);
`ifdef UART_TX_PARITY_EN
      check("frame parity", cap_bits[9], tbl[i].exp_par);
`endif
      repeat (3) step();
    end

    // data_valid held high: 00 then FF back to back
    bus.data       = 8'h00;
    bus.data_valid = 1'b1;
    step();
    bus.data = 8'hFF;
    run = 0;
    gap = -1;
    n   = 0;
    while (gap < 0 && n < 2 * FRAME) begin
      step();
      n++;
      if (tx) run++;
      else if (run > 0) gap = run;
    end
    bus.data_valid = 1'b0;
    check("back-to-back stop gap", gap, CPB + 1);
    wait_idle();
    repeat (3) step();

    // Request while busy is ignored
    bus.data       = 8'h3C;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    repeat (39) step();
    bus.data       = 8'hC3;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    wait_idle();
    repeat (3) step();

    // Asynchronous reset in the middle of a frame
    bus.data       = 8'h96;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    while (m_t < 70) step();
    check("tx low before mid-frame reset", tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset tx", tx, 1'b1);
    check("async reset ready", bus.ready, 1'b1);
    check("async reset tx_done", tx_done, 1'b0);
    if (m_busy) void'(exp_q.pop_back());
    m_busy  = 1'b0;
    rx_busy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();
    run_frame(8'h5A);
    check("frame after reset", {cap_bits[NBITS-1], cap_bits[8:0]}, 10'b1010110100);
    repeat (2) step();

    // Random traffic
    repeat (3000) begin
      bus.data_valid = ($urandom_range(0, 3) == 0);
      bus.data       = 8'($urandom_range(0, 255));
      step();
    end
    bus.data_valid = 1'b0;
    wait_idle();
    repeat (4) step();
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
